// File: rtl/pas_branch_predictor_pkg.sv
// Shared branch-predictor configuration and types for the PAs predictor.
package pas_branch_predictor_pkg;

    // Micro-architecture configuration
    localparam int CONF_FETCH_WIDTH                     = 2;
    localparam int CONF_PHT_ENTRY_NUM                   = 2048;
    localparam int CONF_LHT_ENTRY_NUM                   = 256;
    localparam int CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH = 5;

    localparam int PHT_INDEX_BIT_WIDTH = $clog2(CONF_PHT_ENTRY_NUM);
    localparam int LHT_INDEX_BIT_WIDTH = $clog2(CONF_LHT_ENTRY_NUM);

    typedef logic [PHT_INDEX_BIT_WIDTH-1:0]                  PHT_IndexPath;
    typedef logic [LHT_INDEX_BIT_WIDTH-1:0]                  LHT_IndexPath;
    typedef logic [CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH-1:0] LocalHistoryPath;
    typedef logic [1:0]                                      PHT_CounterPath;

    // Predictor control states
    typedef enum logic {
        PAS_ST_INIT  = 1'b0,
        PAS_ST_READY = 1'b1
    } pas_state_e;

    // 2-bit saturating counter step: taken counts up, not-taken counts down
    function automatic PHT_CounterPath pht_cnt_next(input PHT_CounterPath c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/pas_branch_predictor_table.sv
// Multi-read, single-write table: asynchronous reads, synchronous write.
// Contents are never reset; the owner sweeps them after reset.
module pas_table_ram #(
    parameter int DEPTH    = 256,
    parameter int DATA_W   = 2,
    parameter int RD_PORTS = 3,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic [RD_PORTS-1:0][ADDR_W-1:0]    i_raddr,
    output logic [RD_PORTS-1:0][DATA_W-1:0]    o_rdata,
    input  logic                               i_we,
    input  logic [ADDR_W-1:0]                  i_waddr,
    input  logic [DATA_W-1:0]                  i_wdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Single write port, committed at the clock edge
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Combinational reads; a same-cycle write is not visible until next cycle
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) o_rdata[p] = r_mem[i_raddr[p]];
    end

endmodule

// File: rtl/pas_branch_predictor.sv
// PAs branch predictor: per-PC local history selects a 2-bit counter in a
// pattern history table. One-cycle lookup, commit-time update, and a
// post-reset sweep that initialises both tables.
module pas_branch_predictor
    import pas_branch_predictor_pkg::*;
#(
    parameter int FETCH_WIDTH   = CONF_FETCH_WIDTH,
    parameter int PHT_ENTRY_NUM = CONF_PHT_ENTRY_NUM,
    parameter int LHT_ENTRY_NUM = CONF_LHT_ENTRY_NUM,
    parameter int HIST_W        = CONF_BRANCH_GLOBAL_HISTORY_BIT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FETCH_WIDTH-1:0]             lookup_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]       lookup_pc,
    output logic [FETCH_WIDTH-1:0]             pred_valid,
    output logic [FETCH_WIDTH-1:0]             pred_taken,
    output logic [FETCH_WIDTH-1:0][HIST_W-1:0] pred_hist,
    input  logic                               upd_valid,
    input  logic [31:0]                        upd_pc,
    input  logic [HIST_W-1:0]                  upd_hist,
    input  logic                               upd_taken,
    output logic                               ready
);

    localparam int PHT_IDX_W = $clog2(PHT_ENTRY_NUM);
    localparam int LHT_IDX_W = $clog2(LHT_ENTRY_NUM);
    localparam int PC_IDX_W  = PHT_IDX_W - HIST_W;   // PC bits feeding the PHT index
    localparam int NRD       = FETCH_WIDTH + 1;      // lookup lanes + update port
    localparam int UPD       = FETCH_WIDTH;          // read-port slot used by updates

    pas_state_e                        r_state, w_state_nxt;
    logic [PHT_IDX_W-1:0]              r_init_ptr, w_init_ptr_nxt;
    logic                              w_ready;

    logic [NRD-1:0][LHT_IDX_W-1:0]     w_lht_raddr;
    logic [NRD-1:0][HIST_W-1:0]        w_lht_rdata;
    logic [NRD-1:0][PHT_IDX_W-1:0]     w_pht_raddr;
    logic [NRD-1:0][1:0]               w_pht_rdata;

    logic                              w_pht_we, w_lht_we;
    logic [PHT_IDX_W-1:0]              w_pht_waddr;
    logic [LHT_IDX_W-1:0]              w_lht_waddr;
    PHT_CounterPath                    w_pht_wdata;
    logic [HIST_W-1:0]                 w_lht_wdata;
    logic                              w_init_lht;

    logic [FETCH_WIDTH-1:0]             r_pred_valid, r_pred_taken;
    logic [FETCH_WIDTH-1:0][HIST_W-1:0] r_pred_hist;

    // PC bits outside the index fields are intentionally ignored
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{lookup_pc, upd_pc};

    assign w_ready = (r_state == PAS_ST_READY);
    assign ready   = w_ready;

    // Read-port addressing: lanes chain LHT -> PHT, update port uses the carried history
    for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
        assign w_lht_raddr[l] = lookup_pc[l][2 +: LHT_IDX_W];
        assign w_pht_raddr[l] = {lookup_pc[l][2 +: PC_IDX_W], w_lht_rdata[l]};
    end
    assign w_lht_raddr[UPD] = upd_pc[2 +: LHT_IDX_W];
    assign w_pht_raddr[UPD] = {upd_pc[2 +: PC_IDX_W], upd_hist};

    assign w_init_lht = ({1'b0, r_init_ptr} < (PHT_IDX_W+1)'(LHT_ENTRY_NUM));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PAS_ST_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_ptr <= w_init_ptr_nxt;
        end
    end

    // FSM next state: sweep every PHT entry once, then stay ready until reset
    always_comb begin
        w_state_nxt    = r_state;
        w_init_ptr_nxt = r_init_ptr;
        case (r_state)
            PAS_ST_INIT: begin
                w_init_ptr_nxt = r_init_ptr + 1'b1;
                if (r_init_ptr == PHT_IDX_W'(PHT_ENTRY_NUM - 1)) w_state_nxt = PAS_ST_READY;
            end
            default: w_state_nxt = PAS_ST_READY;
        endcase
    end

    // Table write mux: sweep writes during INIT, committed updates once ready
    always_comb begin
        w_pht_we    = 1'b0;
        w_pht_waddr = w_pht_raddr[UPD];
        w_pht_wdata = pht_cnt_next(w_pht_rdata[UPD], upd_taken);
        w_lht_we    = 1'b0;
        w_lht_waddr = w_lht_raddr[UPD];
        w_lht_wdata = {w_lht_rdata[UPD][HIST_W-2:0], upd_taken};
        if (!w_ready) begin
            w_pht_we    = 1'b1;
            w_pht_waddr = r_init_ptr;
            w_pht_wdata = 2'b01;
            w_lht_we    = w_init_lht;
            w_lht_waddr = r_init_ptr[LHT_IDX_W-1:0];
            w_lht_wdata = '0;
        end else if (upd_valid) begin
            w_pht_we = 1'b1;
            w_lht_we = 1'b1;
        end
    end

    pas_table_ram #(
        .DEPTH(PHT_ENTRY_NUM), .DATA_W(2), .RD_PORTS(NRD)
    ) u_pht (
        .clk(clk), .i_raddr(w_pht_raddr), .o_rdata(w_pht_rdata),
        .i_we(w_pht_we), .i_waddr(w_pht_waddr), .i_wdata(w_pht_wdata)
    );

    pas_table_ram #(
        .DEPTH(LHT_ENTRY_NUM), .DATA_W(HIST_W), .RD_PORTS(NRD)
    ) u_lht (
        .clk(clk), .i_raddr(w_lht_raddr), .o_rdata(w_lht_rdata),
        .i_we(w_lht_we), .i_waddr(w_lht_waddr), .i_wdata(w_lht_wdata)
    );

    // Registered predictions; idle or not-ready lanes are held at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= '0;
            r_pred_taken <= '0;
            r_pred_hist  <= '0;
        end else begin
            for (int l = 0; l < FETCH_WIDTH; l++) begin
                r_pred_valid[l] <= lookup_valid[l] & w_ready;
                r_pred_taken[l] <= lookup_valid[l] & w_ready & w_pht_rdata[l][1];
                r_pred_hist[l]  <= (lookup_valid[l] & w_ready) ? w_lht_rdata[l] : '0;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_hist  = r_pred_hist;

endmodule

// File: tb/tb_pas_branch_predictor.sv
// Randomised self-checking bench for pas_branch_predictor with a table-level model.
module tb_pas_branch_predictor;

    localparam int FW  = 2;
    localparam int PHT = 2048;
    localparam int LHT = 256;
    localparam int HW  = 5;
    localparam int PC_BITS = 11 - HW;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [FW-1:0]              lookup_valid;
    logic [FW-1:0][31:0]        lookup_pc;
    logic [FW-1:0]              pred_valid, pred_taken;
    logic [FW-1:0][HW-1:0]      pred_hist;
    logic                       upd_valid, upd_taken;
    logic [31:0]                upd_pc;
    logic [HW-1:0]              upd_hist;
    logic                       ready;

    int n_chk = 0;
    int n_fail = 0;
    int pht_m [PHT];
    int lht_m [LHT];
    int init_left;

    pas_branch_predictor #(
        .FETCH_WIDTH(FW), .PHT_ENTRY_NUM(PHT), .LHT_ENTRY_NUM(LHT), .HIST_W(HW)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pidx(input logic [31:0] pc, input int h);
        return ((int'(pc >> 2) & ((1 << PC_BITS) - 1)) << HW) | h;
    endfunction

    function automatic int lidx(input logic [31:0] pc);
        return int'(pc >> 2) & (LHT - 1);
    endfunction

    // State of the tables once the sweep has finished
    task automatic mdl_sweep();
        for (int i = 0; i < PHT; i++) pht_m[i] = 1;
        for (int i = 0; i < LHT; i++) lht_m[i] = 0;
        init_left = PHT;
    endtask

    // One clock: predict from pre-edge tables, apply effects, then check after the edge
    task automatic cycle();
        logic [FW-1:0]         ev, et;
        logic [FW-1:0][HW-1:0] eh;
        logic                  er;
        int                    p, l;
        ev = '0; et = '0; eh = '0;
        for (int i = 0; i < FW; i++) begin
            if (!rst && init_left == 0 && lookup_valid[i]) begin
                ev[i] = 1'b1;
                eh[i] = HW'(lht_m[lidx(lookup_pc[i])]);
                et[i] = pht_m[pidx(lookup_pc[i], int'(eh[i]))] >= 2;
            end
        end
        if (rst) mdl_sweep();
        else if (init_left > 0) init_left--;
        else if (upd_valid) begin
            p = pidx(upd_pc, int'(upd_hist));
            l = lidx(upd_pc);
            if (upd_taken) pht_m[p] = (pht_m[p] < 3) ? pht_m[p] + 1 : 3;
            else           pht_m[p] = (pht_m[p] > 0) ? pht_m[p] - 1 : 0;
            lht_m[l] = ((lht_m[l] << 1) | int'(upd_taken)) & ((1 << HW) - 1);
        end
        er = !rst && init_left == 0;
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(er));
        chk("pred_valid", 32'(pred_valid), 32'(ev));
        chk("pred_taken", 32'(pred_taken), 32'(et));
        chk("pred_hist", 32'(pred_hist), 32'(eh));
    endtask

    task automatic idle();
        lookup_valid = '0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_hist = '0; upd_taken = 1'b0;
    endtask

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 9);
    endfunction

    task automatic rnd_inputs(input int upd_pct);
        lookup_valid = FW'($urandom);
        for (int i = 0; i < FW; i++) lookup_pc[i] = rnd_pc();
        if ($urandom_range(0, 3) == 0) lookup_pc[1] = lookup_pc[0];
        upd_valid = ($urandom_range(0, 99) < upd_pct);
        upd_pc    = rnd_pc();
        upd_hist  = HW'($urandom);
        upd_taken = ($urandom_range(0, 2) != 0);
    endtask

    task automatic lookup1(input logic [31:0] pc);
        idle();
        lookup_valid = 2'b11; lookup_pc[0] = pc; lookup_pc[1] = pc;
    endtask

    task automatic update1(input logic [31:0] pc, input logic [HW-1:0] h, input logic t);
        idle();
        upd_valid = 1'b1; upd_pc = pc; upd_hist = h; upd_taken = t;
    endtask

    task automatic run_init_sweep();
        for (int c = 0; c < PHT - 1; c++) begin
            rnd_inputs(50);
            cycle();
        end
        chk("ready_before_2048", 32'(ready), 32'd0);
        rnd_inputs(50);
        cycle();
        chk("ready_at_2048", 32'(ready), 32'd1);
    endtask

    // Asserts reset between edges and checks the outputs drop without a clock
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_valid", 32'(pred_valid), 32'd0);
        chk("async_taken", 32'(pred_taken), 32'd0);
        chk("async_hist",  32'(pred_hist), 32'd0);
        idle();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        mdl_sweep();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b0;
        run_init_sweep();

        // Fresh entry looks up as weakly not-taken with empty history
        idle(); lookup_valid = 2'b01; lookup_pc[0] = 32'h100;
        cycle();
        chk("first_valid", 32'(pred_valid[0]), 32'd1);
        chk("first_taken", 32'(pred_taken[0]), 32'd0);
        chk("first_hist",  32'(pred_hist[0]), 32'd0);

        // Same-cycle lookup and update see the old table contents
        lookup1(32'h200);
        upd_valid = 1'b1; upd_pc = 32'h200; upd_hist = '0; upd_taken = 1'b1;
        cycle();
        chk("nobypass_taken", 32'(pred_taken[0]), 32'd0);
        chk("nobypass_hist",  32'(pred_hist[0]), 32'd0);
        lookup1(32'h200);
        cycle();
        chk("after_upd_hist", 32'(pred_hist[1]), 32'd1);

        // Saturation: counter at PHT index 0 goes 2 -> 3 -> 3, history 00011
        update1(32'h100, '0, 1'b1); cycle();
        update1(32'h100, '0, 1'b1); cycle();
        lookup1(32'h100); cycle();
        chk("hist_0x100", 32'(pred_hist[0]), 32'd3);
        lookup1(32'h000); cycle();
        chk("sat_hi_taken", 32'(pred_taken[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin update1(32'h100, '0, 1'b0); cycle(); end
        update1(32'h100, '0, 1'b1); cycle();
        lookup1(32'h000); cycle();
        chk("sat_lo_taken", 32'(pred_taken[0]), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rnd_inputs(50);
            cycle();
        end

        // Reset in the middle of the sweep restarts it from the beginning
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
        for (int c = 0; c < 500; c++) begin rnd_inputs(50); cycle(); end
        async_reset();
        run_init_sweep();

        // Train some entries, then reset while running and confirm everything reverts
        for (int c = 0; c < 10; c++) begin rnd_inputs(100); upd_taken = 1'b1; cycle(); end
        lookup1(rnd_pc()); cycle();
        async_reset();
        run_init_sweep();
        for (int c = 0; c < 64; c++) begin
            lookup1(rnd_pc());
            lookup_pc[1] = rnd_pc();
            cycle();
            chk("post_reset_taken", 32'(pred_taken), 32'd0);
            chk("post_reset_hist",  32'(pred_hist), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
